// File: rtl/dp_issue_seq.sv
// Datapath issue sequencer: buffers 36-bit instructions in a FIFO and expands each into rpt+1 issues; pop-to-issue one cycle after accept.
// Backpressure: in_ready = !full (FIFO count only); pause inserts bubbles. DP_ISSUE_SEQ_STATS_EN adds a saturating issue_count port.
module dp_issue_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int ZERO_R0    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] in_instr,
  input  logic        pause,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  Y1,
  output logic [3:0]  Y2,
  output logic [3:0]  zero_reg,
  output logic [1:0]  write,
  output logic        busy,
  output logic        seq_done
`ifdef DP_ISSUE_SEQ_STATS_EN
  ,
  output logic [15:0] issue_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0] rpt;
    logic [1:0] write;
    logic [3:0] y2;
    logic [3:0] y1;
    logic [3:0] d;
    logic [3:0] c;
    logic [3:0] b;
    logic [3:0] a;
    logic [1:0] vec;
    logic       form;
    logic [2:0] op;
  } instr_t;

  typedef enum logic {S_IDLE, S_REPEAT} state_t;

  // Instruction FIFO
  instr_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill, fill_nxt;
  logic          push, pop, fifo_vld;
  instr_t        head;

  assign in_ready = !fill[AW];
  assign fifo_vld = (fill != '0);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    fill_nxt = fill;
    if (push && !pop)
      fill_nxt = fill + (AW+1)'(1);
    else if (pop && !push)
      fill_nxt = fill - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_instr;
  end

  // Issue stage; iss.rpt doubles as the remaining-repeat counter
  state_t     state, state_nxt;
  instr_t     iss, iss_nxt;
  logic [1:0] write_nxt;
  logic [3:0] zero_nxt;
  logic       seq_done_nxt, busy_nxt, issue;

  always_comb begin
    state_nxt    = state;
    iss_nxt      = iss;
    write_nxt    = 2'b00;
    seq_done_nxt = 1'b0;
    pop          = 1'b0;
    issue        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!pause && fifo_vld) begin
          pop          = 1'b1;
          issue        = 1'b1;
          iss_nxt      = head;
          seq_done_nxt = (head.rpt == 4'd0);
          if (head.rpt != 4'd0)
            state_nxt = S_REPEAT;
        end
      end
      S_REPEAT: begin
        if (!pause) begin
          issue        = 1'b1;
          iss_nxt.a    = iss.a + 4'd1;
          iss_nxt.b    = iss.b + 4'd1;
          iss_nxt.c    = iss.c + 4'd1;
          iss_nxt.d    = iss.d + 4'd1;
          iss_nxt.y1   = iss.y1 + 4'd1;
          iss_nxt.y2   = iss.y2 + 4'd1;
          iss_nxt.rpt  = iss.rpt - 4'd1;
          seq_done_nxt = (iss.rpt == 4'd1);
          if (iss.rpt == 4'd1)
            state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (issue)
      write_nxt = iss_nxt.write;
    zero_nxt = (ZERO_R0 != 0) ? {iss_nxt.d == 4'd0, iss_nxt.c == 4'd0,
                                 iss_nxt.b == 4'd0, iss_nxt.a == 4'd0} : 4'b0000;
    busy_nxt = (fill_nxt != '0) || (state_nxt == S_REPEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      iss      <= '0;
      write    <= 2'b00;
      zero_reg <= 4'b0000;
      seq_done <= 1'b0;
      busy     <= 1'b0;
      fill     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      iss      <= iss_nxt;
      write    <= write_nxt;
      seq_done <= seq_done_nxt;
      busy     <= busy_nxt;
      fill     <= fill_nxt;
      if (issue)
        zero_reg <= zero_nxt;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  assign op   = iss.op;
  assign form = iss.form;
  assign vec  = iss.vec;
  assign A    = iss.a;
  assign B    = iss.b;
  assign C    = iss.c;
  assign D    = iss.d;
  assign Y1   = iss.y1;
  assign Y2   = iss.y2;

`ifdef DP_ISSUE_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      issue_count <= 16'd0;
    else if (issue && issue_count != 16'hFFFF)
      issue_count <= issue_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dp_issue_seq.sv
// Randomized bench for dp_issue_seq against a queue-based model: issue k of an instruction carries base index + k.
module tb_dp_issue_seq;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, pause;
  logic [35:0] in_instr;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D, Y1, Y2, zero_reg;
  logic [1:0]  write;
  logic        busy, seq_done;
`ifdef DP_ISSUE_SEQ_STATS_EN
  logic [15:0] issue_count;
`endif

  dp_issue_seq #(.FIFO_DEPTH(DEPTH), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .pause(pause), .op(op), .form(form), .vec(vec), .A(A), .B(B), .C(C), .D(D),
    .Y1(Y1), .Y2(Y2), .zero_reg(zero_reg), .write(write), .busy(busy), .seq_done(seq_done)
`ifdef DP_ISSUE_SEQ_STATS_EN
    , .issue_count(issue_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: pending instructions, the one being expanded, its iteration k and issues left
  logic [35:0] q[$];
  logic [35:0] cur;
  int          k, rem, e_cnt;
  logic [29:0] e_ctl;
  logic [1:0]  e_write;
  logic [3:0]  e_zero;
  logic        e_done;

  function automatic logic [35:0] mk(input logic [2:0] o, input logic [3:0] a, b, c, d, y1, y2,
                                     input logic [1:0] w, input logic [3:0] rpt);
    return {rpt, w, y2, y1, d, c, b, a, 2'b00, 1'b0, o};
  endfunction

  task automatic model_issue();
    logic [3:0] idx [6];
    for (int i = 0; i < 6; i++)
      idx[i] = 4'((int'(cur[6+4*i +: 4]) + k) % 16);
    e_ctl   = {cur[2:0], cur[3], cur[5:4], idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]};
    e_zero  = {idx[3] == 4'd0, idx[2] == 4'd0, idx[1] == 4'd0, idx[0] == 4'd0};
    e_write = cur[31:30];
    e_done  = (k == int'(cur[35:32]));
    if (e_cnt < 65535) e_cnt++;
  endtask

  // One clock: drive inputs, check in_ready, advance the model at the edge, check outputs after it
  task automatic step(input logic v, input logic [35:0] ins, input logic p, input logic r,
                      output logic acc);
    in_valid = v; in_instr = ins; pause = p; rst = r;
    #1;
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    acc = !r && v && (q.size() < DEPTH);
    @(posedge clk);
    if (r) begin
      q.delete(); rem = 0; k = 0; e_cnt = 0;
      e_ctl = '0; e_write = '0; e_zero = '0; e_done = 1'b0;
    end else begin
      e_write = 2'b00;
      e_done  = 1'b0;
      if (rem > 0) begin
        if (!p) begin k++; rem--; model_issue(); end
      end else if (!p && q.size() > 0) begin
        cur = q.pop_front(); k = 0; rem = int'(cur[35:32]); model_issue();
      end
      if (acc) q.push_back(ins);
    end
    #1;
    check("ctl", 32'({op, form, vec, A, B, C, D, Y1, Y2}), 32'(e_ctl));
    check("write", 32'(write), 32'(e_write));
    check("zero_reg", 32'(zero_reg), 32'(e_zero));
    check("seq_done", 32'(seq_done), 32'(e_done));
    check("busy", 32'(busy), 32'((q.size() > 0) || (rem > 0)));
`ifdef DP_ISSUE_SEQ_STATS_EN
    check("issue_count", 32'(issue_count), 32'(e_cnt));
`endif
  endtask

  initial begin
    logic        a;
    logic [35:0] ins;
    logic        v, p, r;
    in_valid = 1'b0; in_instr = '0; pause = 1'b0; rst = 1'b1;
    cur = '0; k = 0; rem = 0; e_cnt = 0;
    e_ctl = '0; e_write = '0; e_zero = '0; e_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0, 1'b1, a);

    // single issue
    step(1'b1, mk(3'd3, 4'd1, 4'd2, 4'd0, 4'd0, 4'd7, 4'd0, 2'b01, 4'd0), 1'b0, 1'b0, a);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, a);

    // repeat with index wrap
    step(1'b1, mk(3'd5, 4'd14, 4'd3, 4'd3, 4'd3, 4'd15, 4'd3, 2'b11, 4'd2), 1'b0, 1'b0, a);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, a);

    // pause mid-repeat
    step(1'b1, mk(3'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 2'b10, 4'd3), 1'b0, 1'b0, a);
    step(1'b0, '0, 1'b0, 1'b0, a);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, a);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, a);

    // backpressure: fill while paused, then release until the fifth is taken
    for (int i = 0; i < 5; i++)
      step(1'b1, mk(3'(i), 4'(i), 4'(i+1), 4'(i+2), 4'(i+3), 4'(i+4), 4'(i+5), 2'b01, 4'd0),
           1'b1, 1'b0, a);
    a = 1'b0;
    for (int i = 0; i < 8 && !a; i++)
      step(1'b1, mk(3'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 2'b01, 4'd0), 1'b0, 1'b0, a);
    repeat (6) step(1'b0, '0, 1'b0, 1'b0, a);

    // reset in the middle of a repeat
    step(1'b1, mk(3'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 2'b11, 4'd5), 1'b0, 1'b0, a);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, a);
    step(1'b0, '0, 1'b0, 1'b1, a);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, a);

    // rpt=2 then rpt=0 from a clean reset
    step(1'b0, '0, 1'b0, 1'b1, a);
    step(1'b1, mk(3'd6, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 2'b01, 4'd2), 1'b0, 1'b0, a);
    step(1'b1, mk(3'd7, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 2'b10, 4'd0), 1'b0, 1'b0, a);
    repeat (6) step(1'b0, '0, 1'b0, 1'b0, a);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      ins = 36'({$urandom(), $urandom()});
      ins[35:32] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      v = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, ins, p, r, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
